// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// Define UART_SCHED_TIMEOUT_EN to abort a frame whose tx_busy never rises within BUSY_TIMEOUT cycles.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic                       cfg_pen,
  input  logic                       cfg_peven,
  input  logic                       tx_busy,
  output logic                       tx_en,
  output logic [7:0]                 tx_din,
  output logic                       tx_pen,
  output logic                       tx_peven,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       active,
  output logic                       err
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [ID_W-1:0]     rr_ptr_r, rr_ptr_s;
  logic [ID_W-1:0]     cur_id_r, cur_id_s;
  logic [ID_W-1:0]     winner_s, idx_s;
  logic [ID_W:0]       sum_s;
  logic                found_s;
  logic                timeout_s;

  logic                tx_en_r, tx_en_s;
  logic [7:0]          tx_din_r, tx_din_s;
  logic                tx_pen_r, tx_pen_s;
  logic                tx_peven_r, tx_peven_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic                done_r, done_s;
  logic [ID_W-1:0]     done_id_r, done_id_s;
  logic                active_r, active_s;
  logic                err_r, err_s;

  // Round-robin search: first set req bit at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found_s  = 1'b0;
    winner_s = {ID_W{1'b0}};
    sum_s    = {(ID_W+1){1'b0}};
    idx_s    = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      if (sum_s >= (ID_W+1)'(NUM_REQ)) begin
        idx_s = ID_W'(sum_s - (ID_W+1)'(NUM_REQ));
      end else begin
        idx_s = sum_s[ID_W-1:0];
      end
      if (!found_s && req[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r;

  // Watchdog counter: cycles spent in WAIT_BUSY for the current frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT_BUSY) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  assign timeout_s = (state_r == ST_WAIT_BUSY) && !tx_busy &&
                     (cnt_r == CNT_W'(BUSY_TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) state_s = ST_WAIT_BUSY;
        else         state_s = ST_IDLE;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy)        state_s = ST_WAIT_DONE;
        else if (timeout_s) state_s = ST_IDLE;
        else                state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_s = ST_IDLE;
        else          state_s = ST_WAIT_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the arbitration bookkeeping.
  always_comb begin
    tx_en_s    = 1'b0;
    gnt_s      = {NUM_REQ{1'b0}};
    done_s     = 1'b0;
    err_s      = 1'b0;
    done_id_s  = done_id_r;
    active_s   = active_r;
    tx_din_s   = tx_din_r;
    tx_pen_s   = tx_pen_r;
    tx_peven_s = tx_peven_r;
    cur_id_s   = cur_id_r;
    rr_ptr_s   = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          tx_en_s    = 1'b1;
          gnt_s      = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
          active_s   = 1'b1;
          tx_din_s   = req_data[{winner_s, 3'b000} +: 8];
          tx_pen_s   = cfg_pen;
          tx_peven_s = cfg_peven;
          cur_id_s   = winner_s;
          if (winner_s == ID_W'(NUM_REQ - 1)) rr_ptr_s = {ID_W{1'b0}};
          else                                rr_ptr_s = winner_s + {{(ID_W-1){1'b0}}, 1'b1};
        end else begin
          active_s = 1'b0;
        end
      end
      ST_WAIT_BUSY: begin
        if (!tx_busy && timeout_s) begin
          err_s    = 1'b1;
          active_s = 1'b0;
        end else begin
          active_s = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          done_s    = 1'b1;
          done_id_s = cur_id_r;
          active_s  = 1'b0;
        end else begin
          active_s  = 1'b1;
        end
      end
      default: begin
        active_s = 1'b0;
      end
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_en_r    <= 1'b0;
      tx_din_r   <= 8'h00;
      tx_pen_r   <= 1'b0;
      tx_peven_r <= 1'b0;
      gnt_r      <= {NUM_REQ{1'b0}};
      done_r     <= 1'b0;
      done_id_r  <= {ID_W{1'b0}};
      active_r   <= 1'b0;
      err_r      <= 1'b0;
      cur_id_r   <= {ID_W{1'b0}};
      rr_ptr_r   <= {ID_W{1'b0}};
    end else begin
      tx_en_r    <= tx_en_s;
      tx_din_r   <= tx_din_s;
      tx_pen_r   <= tx_pen_s;
      tx_peven_r <= tx_peven_s;
      gnt_r      <= gnt_s;
      done_r     <= done_s;
      done_id_r  <= done_id_s;
      active_r   <= active_s;
      err_r      <= err_s;
      cur_id_r   <= cur_id_s;
      rr_ptr_r   <= rr_ptr_s;
    end
  end

  assign tx_en    = tx_en_r;
  assign tx_din   = tx_din_r;
  assign tx_pen   = tx_pen_r;
  assign tx_peven = tx_peven_r;
  assign gnt      = gnt_r;
  assign done     = done_r;
  assign done_id  = done_id_r;
  assign active   = active_r;
  assign err      = err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a one-bit-per-clock transmitter model.
// The watchdog checks follow whether UART_SCHED_TIMEOUT_EN is defined for the build.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        cfg_pen, cfg_peven;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_din;
  logic        tx_pen, tx_peven;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  done_id;
  logic        active;
  logic        err;

  int n_total = 0;
  int n_bad   = 0;

  logic        model_on, model_busy, man_busy;
  int          bit_idx, nbits;
  logic [10:0] frame_out, rx_bits;
  logic [19:0] outs_all;

  assign tx_busy  = model_on ? model_busy : man_busy;
  assign outs_all = {tx_en, tx_din, tx_pen, tx_peven, gnt, done, done_id, active, err};

  uart_tx_scheduler #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .cfg_pen(cfg_pen), .cfg_peven(cfg_peven), .tx_busy(tx_busy),
    .tx_en(tx_en), .tx_din(tx_din), .tx_pen(tx_pen), .tx_peven(tx_peven),
    .gnt(gnt), .done(done), .done_id(done_id), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  // Transmitter model: start, 8 data bits LSB first, optional parity, stop; one bit per clock.
  always @(negedge clk) begin
    if (!rst) begin
      model_busy = 1'b0;
      bit_idx    = 0;
    end else if (model_busy) begin
      bit_idx = bit_idx + 1;
      if (bit_idx >= nbits) model_busy = 1'b0;
      else rx_bits[bit_idx] = frame_out[bit_idx];
    end else if (tx_en) begin
      if (tx_pen) frame_out = {1'b1, (tx_peven ? ^tx_din : ~^tx_din), tx_din, 1'b0};
      else        frame_out = {2'b11, tx_din, 1'b0};
      nbits      = tx_pen ? 11 : 10;
      rx_bits    = 11'h7FF;
      rx_bits[0] = frame_out[0];
      bit_idx    = 0;
      model_busy = 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input int max_cyc, output logic [3:0] g, output int cyc, output logic prev_act);
    g = 4'b0000;
    cyc = 0;
    prev_act = active;
    for (int i = 1; i <= max_cyc; i++) begin
      prev_act = active;
      @(negedge clk);
      if (gnt != 4'b0000) begin
        g = gnt;
        cyc = i;
        break;
      end
    end
    check_val("gnt_seen", 32'(cyc != 0), 32'd1);
  endtask

  task automatic wait_done(input int max_cyc, output logic [1:0] id, output logic err_seen);
    int cyc;
    cyc = 0;
    id = 2'd0;
    err_seen = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (err) err_seen = 1'b1;
      if (done) begin
        id = done_id;
        cyc = i;
        break;
      end
    end
    check_val("done_seen", 32'(cyc != 0), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    logic [1:0] id;
    logic       pa, es;
    int         cyc, cnt;
    int         exp_id [5] = '{0, 1, 2, 3, 0};

    rst = 1'b0; req = 4'b0000; cfg_pen = 1'b0; cfg_peven = 1'b0;
    req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
    model_on = 1'b1; man_busy = 1'b0;
    rx_bits = 11'h7FF; frame_out = 11'h7FF; nbits = 10;

    // 1: reset state and quiet idle
    repeat (3) @(negedge clk);
    check_val("reset_outs", 32'(outs_all), 32'd0);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_en || gnt != 4'b0000 || active) cnt++;
    end
    check_val("idle_quiet", 32'(cnt), 32'd0);

    // 2: single request, byte A5, even parity
    req = 4'b0010; cfg_pen = 1'b1; cfg_peven = 1'b1;
    wait_gnt(10, g, cyc, pa);
    req = 4'b0000;
    check_val("single_gnt", 32'(g), 32'h2);
    check_val("single_lat", 32'(cyc), 32'd1);
    check_val("single_en", 32'(tx_en), 32'd1);
    check_val("single_din", 32'(tx_din), 32'hA5);
    check_val("single_par", 32'({tx_pen, tx_peven, active}), 32'h7);
    @(negedge clk);
    check_val("pulse_clear", 32'({tx_en, gnt, active}), 32'h1);
    wait_done(60, id, es);
    check_val("single_id", 32'(id), 32'd1);
    check_val("single_inact", 32'(active), 32'd0);
    check_val("single_data", 32'(rx_bits[8:1]), 32'hA5);
    check_val("single_pbit", 32'(rx_bits[10:9]), 32'h2);

    // 3: round robin with all requests held
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(10, g, cyc, pa);
      check_val("rr_gnt", 32'(g), 32'(4'b0001 << exp_id[k]));
      check_val("rr_gap", 32'(pa), 32'd0);
      check_val("rr_din", 32'(tx_din), 32'(8'h11 * (exp_id[k] + 1)));
      if (k == 4) req = 4'b0000;
      wait_done(60, id, es);
      check_val("rr_id", 32'(id), 32'(exp_id[k]));
    end

    // 4: wrap and skip
    do_reset();
    req = 4'b0100;
    wait_gnt(10, g, cyc, pa); req = 4'b0000;
    check_val("wrap_g2", 32'(g), 32'h4);
    wait_done(60, id, es);
    req = 4'b0101;
    wait_gnt(10, g, cyc, pa); req = 4'b0100;
    check_val("wrap_g0", 32'(g), 32'h1);
    wait_done(60, id, es);
    wait_gnt(10, g, cyc, pa); req = 4'b0000;
    check_val("skip_g2", 32'(g), 32'h4);
    wait_done(60, id, es);
    req = 4'b0001;
    wait_gnt(10, g, cyc, pa);
    check_val("only0_a", 32'(g), 32'h1);
    wait_done(60, id, es);
    wait_gnt(10, g, cyc, pa);
    check_val("only0_b", 32'(g), 32'h1);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    wait_done(60, id, es);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) cnt++;
    end
    check_val("withdraw", 32'(cnt), 32'd0);

    // 5: reset at data bit D3, then requester 0 wins
    req = 4'b0010;
    wait_gnt(10, g, cyc, pa); req = 4'b0000;
    check_val("mid_gnt", 32'(g), 32'h2);
    cnt = 0;
    for (int i = 0; i < 40 && bit_idx != 4; i++) begin
      @(negedge clk);
      cnt++;
    end
    check_val("mid_d3", 32'(bit_idx), 32'd4);
    rst = 1'b0;
    #1;
    check_val("mid_rst_outs", 32'(outs_all), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1001;
    wait_gnt(10, g, cyc, pa); req = 4'b0000;
    check_val("mid_next", 32'(g), 32'h1);
    wait_done(60, id, es);

    // cfg change during a frame is ignored (odd parity on 3C gives parity bit 1)
    req_data = {8'h44, 8'h33, 8'h22, 8'h3C};
    cfg_pen = 1'b1; cfg_peven = 1'b0;
    req = 4'b0001;
    wait_gnt(10, g, cyc, pa); req = 4'b0000;
    cfg_pen = 1'b0; cfg_peven = 1'b1;
    wait_done(60, id, es);
    check_val("cfg_hold", 32'({tx_pen, tx_peven}), 32'h2);
    check_val("cfg_data", 32'(rx_bits[8:1]), 32'h3C);
    check_val("cfg_pbit", 32'(rx_bits[10:9]), 32'h3);

    // busy already high when the frame starts
    model_on = 1'b0; man_busy = 1'b1;
    req = 4'b0001;
    wait_gnt(10, g, cyc, pa); req = 4'b0000;
    @(negedge clk);
    man_busy = 1'b0;
    @(negedge clk);
    check_val("early_busy", 32'({done, done_id}), 32'h4);

    // 6: busy never rises
    @(negedge clk);
    req = 4'b0001;
    wait_gnt(10, g, cyc, pa); req = 4'b0000;
`ifdef UART_SCHED_TIMEOUT_EN
    cyc = 0; es = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) es = 1'b1;
      if (err) begin
        cyc = i;
        break;
      end
    end
    check_val("to_cycles", 32'(cyc), 32'd16);
    check_val("to_nodone", 32'(es), 32'd0);
    check_val("to_inact", 32'(active), 32'd0);
    @(negedge clk);
    check_val("to_pulse", 32'({err, done, active}), 32'd0);
`else
    es = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (err || done) es = 1'b1;
    end
    check_val("noto_active", 32'(active), 32'd1);
    check_val("noto_err", 32'(es), 32'd0);
`endif
    do_reset();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
